// File: rtl/instr_decoder.sv
// Instruction decoder and fetch sequencer: walks pc through IDLE/RUN/HALT,
// resolves branches and registers the ALU opcode/operand one cycle after fetch.
module instr_decoder #(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic            instr_valid,
    input  logic            zero_flag,
    output logic [PC_W-1:0] pc,
    output logic            fetch_en,
    output logic [3:0]      alu_op,
    output logic [2:0]      operand,
    output logic            op_valid,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        CLS_FIN    = 3'd0,
        CLS_RESET  = 3'd1,
        CLS_BRANCH = 3'd2,
        CLS_NOP    = 3'd3,
        CLS_ALU    = 3'd4
    } instrClass_t;

    localparam logic [8:0] INSTR_FIN    = 9'b000111000;
    localparam logic [8:0] INSTR_RESET  = 9'b000111001;
    localparam logic [3:0] OP_PASS_VAL  = 4'b0000;
    localparam logic [3:0] OP_MAX_LEGAL = 4'b1000;
    localparam logic [3:0] OP_UNK       = 4'b1111;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [3:0]      aluOp_q, aluOp_d;
    logic [2:0]      operand_q, operand_d;
    logic            opValid_q, opValid_d;
    logic            illegal_q, illegal_d;

    instrClass_t     instrClass;
    logic            branchTaken;
    logic [PC_W-1:0] branchOffset;
    logic [PC_W-1:0] pcPlusOne;
    logic [PC_W-1:0] pcBranch;

    // Priority matters: FIN and RESET live inside the ZSERIES encoding space.
    always_comb begin
        if (instr == INSTR_FIN) begin
            instrClass = CLS_FIN;
        end else if (instr == INSTR_RESET) begin
            instrClass = CLS_RESET;
        end else if (instr[8:7] == 2'b11) begin
            instrClass = CLS_BRANCH;
        end else if (instr[8:6] == 3'b000) begin
            instrClass = CLS_NOP;
        end else begin
            instrClass = CLS_ALU;
        end
    end

    // Offset is sign-extended so the PC_W-bit add wraps naturally modulo 2^PC_W.
    assign branchTaken  = !instr[6] || zero_flag;
    assign branchOffset = PC_W'(signed'(instr[5:0]));
    assign pcPlusOne    = pc_q + PC_W'(1);
    assign pcBranch     = pc_q + branchOffset;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        aluOp_d   = aluOp_q;
        operand_d = operand_q;
        opValid_d = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                end
            end
            RUN: begin
                if (instr_valid) begin
                    case (instrClass)
                        CLS_FIN: begin
                            state_d = HALT;
                        end
                        CLS_RESET: begin
                            pc_d = '0;
                        end
                        CLS_BRANCH: begin
                            pc_d = branchTaken ? pcBranch : pcPlusOne;
                        end
                        CLS_NOP: begin
                            pc_d = pcPlusOne;
                        end
                        default: begin
                            pc_d      = pcPlusOne;
                            operand_d = instr[2:0];
                            opValid_d = 1'b1;
                            if (instr[6:3] <= OP_MAX_LEGAL) begin
                                aluOp_d = instr[6:3];
                            end else begin
                                aluOp_d   = OP_UNK;
                                illegal_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            aluOp_q   <= OP_PASS_VAL;
            operand_q <= 3'b000;
            opValid_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            aluOp_q   <= aluOp_d;
            operand_q <= operand_d;
            opValid_q <= opValid_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc       = pc_q;
    assign fetch_en = (state_q == RUN);
    assign halted   = (state_q == HALT);
    assign alu_op   = aluOp_q;
    assign operand  = operand_q;
    assign op_valid = opValid_q;
    assign illegal  = illegal_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Scoreboard bench for instr_decoder: directed scenarios plus random traffic,
// checked against a rule-level model of the decoder's architectural state.
module tb_instr_decoder;

    localparam int PC_W  = 8;
    localparam int PCMOD = 1 << PC_W;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic            clk;
    logic            reset;
    logic            start;
    logic [8:0]      instr;
    logic            instr_valid;
    logic            zero_flag;
    logic [PC_W-1:0] pc;
    logic            fetch_en;
    logic [3:0]      alu_op;
    logic [2:0]      operand;
    logic            op_valid;
    logic            halted;
    logic            illegal;

    instr_decoder #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .instr      (instr),
        .instr_valid(instr_valid),
        .zero_flag  (zero_flag),
        .pc         (pc),
        .fetch_en   (fetch_en),
        .alu_op     (alu_op),
        .operand    (operand),
        .op_valid   (op_valid),
        .halted     (halted),
        .illegal    (illegal)
    );

    typedef struct {
        int cyc;
        int pc;
        int fetchEn;
        int aluOp;
        int operand;
        int opValid;
        int halted;
        int illegal;
    } expect_t;

    expect_t sbQ[$];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    int mState = M_IDLE;
    int mPc = 0;
    int mAluOp = 0;
    int mOperand = 0;
    int mOpValid = 0;
    int mIllegal = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic checkField(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, actual, expected);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checkField("pc",       int'(pc),       e.pc);
        checkField("fetch_en", int'(fetch_en), e.fetchEn);
        checkField("alu_op",   int'(alu_op),   e.aluOp);
        checkField("operand",  int'(operand),  e.operand);
        checkField("op_valid", int'(op_valid), e.opValid);
        checkField("halted",   int'(halted),   e.halted);
        checkField("illegal",  int'(illegal),  e.illegal);
    endtask

    // Monitor: compares whatever the DUT presents against the expectation due this cycle.
    always @(negedge clk) begin
        if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
            checkOutput(sbQ.pop_front());
        end
    end

    task automatic modelStep(input logic r, input logic s, input logic [8:0] ins,
                             input logic v, input logic z);
        int off;
        int op;
        mOpValid = 0;
        mIllegal = 0;
        if (r) begin
            mState = M_IDLE; mPc = 0; mAluOp = 0; mOperand = 0;
        end else if (mState != M_RUN) begin
            if (s) begin
                mState = M_RUN; mPc = 0;
            end
        end else if (v) begin
            if (ins == 9'd56) begin
                mState = M_HALT;
            end else if (ins == 9'd57) begin
                mPc = 0;
            end else if (ins[8:7] == 2'b11) begin
                off = int'(ins[5:0]);
                if (off >= 32) off = off - 64;
                if (ins[6] == 1'b0 || z) mPc = ((mPc + off) % PCMOD + PCMOD) % PCMOD;
                else mPc = (mPc + 1) % PCMOD;
            end else if (ins[8:6] == 3'b000) begin
                mPc = (mPc + 1) % PCMOD;
            end else begin
                op = int'(ins[6:3]);
                mPc = (mPc + 1) % PCMOD;
                mOperand = int'(ins[2:0]);
                mOpValid = 1;
                if (op <= 8) mAluOp = op;
                else begin
                    mAluOp = 15; mIllegal = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic [8:0] ins,
                                 input logic v, input logic z);
        expect_t e;
        reset = r; start = s; instr = ins; instr_valid = v; zero_flag = z;
        modelStep(r, s, ins, v, z);
        e.cyc = cyc + 1;
        e.pc = mPc;
        e.fetchEn = (mState == M_RUN) ? 1 : 0;
        e.aluOp = mAluOp;
        e.operand = mOperand;
        e.opValid = mOpValid;
        e.halted = (mState == M_HALT) ? 1 : 0;
        e.illegal = mIllegal;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] randInstr();
        int sel;
        logic [8:0] w;
        sel = $urandom_range(0, 19);
        w = 9'($urandom);
        if (sel == 0) w = 9'b000111000;
        else if (sel == 1) w = 9'b000111001;
        else if (sel < 7) w[8:7] = 2'b11;
        else if (sel < 9) w[8:6] = 3'b000;
        else if (w[8:7] == 2'b11 || w[8:6] == 3'b000) w[8:7] = 2'b01;
        return w;
    endfunction

    initial begin
        applyStimulus(1, 0, 9'd0, 0, 0);
        applyStimulus(1, 1, 9'd0, 1, 0);
        // ADD with operand 5 straight after start
        applyStimulus(0, 1, 9'd0, 0, 0);
        applyStimulus(0, 0, 9'b01_0010_101, 1, 0);
        // Conditional branch back by 2 from pc 5, taken then not taken
        repeat (4) applyStimulus(0, 0, 9'b000_000_000, 1, 0);
        applyStimulus(0, 0, 9'b11_1_111110, 1, 1);
        repeat (2) applyStimulus(0, 0, 9'b000_010_000, 1, 0);
        applyStimulus(0, 0, 9'b11_1_111110, 1, 0);
        // pc wrap: reset instr, jump to -1, then ALU op
        applyStimulus(0, 0, 9'b000111001, 1, 0);
        applyStimulus(0, 0, 9'b11_0_111111, 1, 0);
        applyStimulus(0, 0, 9'b10_0111_011, 1, 0);
        // Undefined opcode, idle cycle, then self-loop branch
        applyStimulus(0, 0, 9'b01_1100_000, 1, 0);
        applyStimulus(0, 1, 9'b01_0001_111, 0, 0);
        applyStimulus(0, 0, 9'b11_0_000000, 1, 0);
        applyStimulus(0, 0, 9'b11_1_000000, 1, 1);
        // FIN at pc 7, ignored fetches while halted, then restart
        applyStimulus(0, 0, 9'b000111001, 1, 0);
        repeat (7) applyStimulus(0, 0, 9'b000_100_010, 1, 0);
        applyStimulus(0, 0, 9'b000111000, 1, 0);
        repeat (2) applyStimulus(0, 0, 9'b01_0011_001, 1, 1);
        applyStimulus(0, 1, 9'b01_0011_001, 1, 0);
        applyStimulus(0, 0, 9'b01_0100_110, 1, 0);
        // Reset colliding with a valid ALU instr, then ignored fetch in IDLE
        applyStimulus(1, 0, 9'b01_0101_011, 1, 0);
        applyStimulus(0, 0, 9'b01_0101_011, 1, 0);
        applyStimulus(1, 1, 9'd0, 0, 0);
        applyStimulus(0, 1, 9'd0, 0, 0);
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                          randInstr(), ($urandom_range(0, 3) != 0), 1'($urandom));
        end
        applyStimulus(0, 0, 9'd0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        checks = checks + 1;
        if (sbQ.size() != 0) begin
            errors = errors + 1;
            $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sbQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
